stopwatch_ctrl_mc: RTL and testbench
====================================

Name: stopwatch_ctrl_mc

Overview:
Multi-channel stopwatch/timer controller that drives up to NUM_CH independent counter datapaths from one shared button set. It sits between the debounced button inputs and the per-channel BCD counters. Per channel it provides an FSM with pause/resume, count-down expiry with auto-stop and timed alarm, lap-freeze, and guarded clear. Internal edge detection means a held button acts once.

Parameters:
NUM_CH, 2, number of independent stopwatch channels (1..8)
SEL_W, 1, width of ch_sel; must be >= clog2(NUM_CH), minimum 1
ALARM_CYCLES, 100000000, clocks alarm stays asserted after expiry (1 s at 100 MHz)
ALARM_W, 27, width of per-channel alarm counter; must hold ALARM_CYCLES

Ports:
clock  input  1  100 MHz clock
reset  input  1  asynchronous, active-high reset
start_button  input  1  debounced level, start/resume
stop_button  input  1  debounced level, pause
clear_button  input  1  debounced level, clear
lap_button  input  1  debounced level, lap freeze toggle
mode_toggle  input  1  debounced level, toggle up/down mode
ch_sel  input  SEL_W  channel addressed by button presses
at_zero  input  NUM_CH  per-channel counter-is-zero flag
running  output  NUM_CH  channel counting enable
direction  output  NUM_CH  1 = up, 0 = down
clear_pulse  output  NUM_CH  one-cycle counter clear
lap_hold  output  NUM_CH  1 = display frozen, counter keeps running
alarm  output  NUM_CH  expiry alarm
load_pulse  output  NUM_CH  one-cycle preset reload (AUTO_RELOAD_EN only, else 0)

Behaviour:
- Reset is asynchronous. All channels go to IDLE. mode_down=0, running=0, direction=1, lap_hold=0, clear_pulse=0, alarm=0, load_pulse=0, edge registers=0.
- Edge detect: press = btn & ~btn_q, with btn_q registered every cycle. A held button produces exactly one press. Changing ch_sel while a button is held produces no new press.
- A press applies only to channel ch_sel. If ch_sel >= NUM_CH, all presses are ignored.
- All outputs are registered. The effect of a press is visible on the cycle after the button is first sampled high.
- Simultaneous presses resolve by priority: clear > stop > start > lap > mode. One action per channel per cycle.
- Per-channel states: IDLE, RUN, PAUSED, EXPIRED. running=1 only in RUN.
- IDLE/PAUSED + start: go to RUN with direction = ~mode_down. Exception: if mode_down=1 and at_zero=1, the press is ignored and the channel stays in its state.
- RUN + stop: go to PAUSED. direction is retained.
- IDLE/PAUSED + clear: clear_pulse=1 for one cycle, lap_hold=0, next state IDLE. Clear in RUN or EXPIRED is ignored, except that EXPIRED + clear acts as acknowledge (see below).
- RUN + lap: toggle lap_hold. Lap in any other state is ignored.
- IDLE/PAUSED + mode_toggle: invert mode_down. Ignored in RUN and EXPIRED.
- RUN with direction=0 and at_zero=1: go to EXPIRED. running=0 on the next cycle. The alarm counter loads 0 and alarm=1.
- Expiry is evaluated for every channel every cycle, independent of ch_sel.
- Expiry takes precedence over a same-cycle stop press.
- In EXPIRED, alarm=1 while counter < ALARM_CYCLES. The counter saturates and alarm drops once it reaches ALARM_CYCLES. The state stays EXPIRED.
- EXPIRED acknowledge:
  - clear press: clear_pulse=1, alarm=0, lap_hold=0, next state IDLE.
  - start or stop press: alarm=0, next state PAUSED.
- An up-counting channel never expires; at_zero is ignored when direction=1.
- Reset mid-operation aborts immediately. No clear_pulse is emitted by reset.

Optional Feature:
Macro: STOPWATCH_AUTO_RELOAD_EN.
- Defined: a RUN/down channel reaching at_zero=1 does not expire. It emits load_pulse=1 for one cycle, stays in RUN, and pulses alarm for exactly 1 cycle (repeating timer).
- Undefined: expiry behaves as above, and load_pulse is constant 0.

Test Plan:
- Reset, then ch_sel=0, start held high for 5 cycles -> running=2'b01 from the cycle after the first high sample, single transition, direction[0]=1.
- Ch0 RUN, stop press -> running[0]=0, state PAUSED. Clear press -> clear_pulse[0]=1 for exactly 1 cycle. Clear press while in RUN -> clear_pulse stays 0.
- ch_sel=1, mode_toggle press, start press, then at_zero[1]=1 -> direction[1]=0, running[1] drops 1 cycle after at_zero. alarm[1]=1 for ALARM_CYCLES (bench: 10), then 0. Clear press -> IDLE with clear_pulse[1]=1.
- Start and clear pressed in the same cycle on PAUSED ch0 -> clear wins: clear_pulse[0]=1, running[0]=0.
- Ch0 RUN, lap press twice -> lap_hold[0] 1 then 0, running[0] stays 1 throughout. ch_sel=3 with NUM_CH=2 plus any press -> no output change.
- With STOPWATCH_AUTO_RELOAD_EN, down-run ch1 with at_zero pulse -> load_pulse[1]=1 for 1 cycle, alarm[1]=1 for 1 cycle, running[1] stays 1.

Source files
------------

// File: rtl/stopwatch_ctrl_mc.sv
// Multi-channel stopwatch controller: per-channel run/pause/expire FSM.
// Define STOPWATCH_AUTO_RELOAD_EN for repeating count-down timers.
module stopwatch_ctrl_mc #(
  parameter int NUM_CH       = 2,
  parameter int SEL_W        = 1,
  parameter int ALARM_CYCLES = 100000000,
  parameter int ALARM_W      = 27
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_button,
  input  logic              stop_button,
  input  logic              clear_button,
  input  logic              lap_button,
  input  logic              mode_toggle,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [NUM_CH-1:0] at_zero,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] direction,
  output logic [NUM_CH-1:0] clear_pulse,
  output logic [NUM_CH-1:0] lap_hold,
  output logic [NUM_CH-1:0] alarm,
  output logic [NUM_CH-1:0] load_pulse
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [ALARM_W-1:0] LP_ALARM = ALARM_W'(ALARM_CYCLES);

`ifdef STOPWATCH_AUTO_RELOAD_EN
  localparam logic LP_RELOAD = 1'b1;
`else
  localparam logic LP_RELOAD = 1'b0;
`endif

  logic [4:0] r_btn_q;
  logic [4:0] w_btn;
  logic [4:0] w_press;
  logic       w_sel_ok;
  logic       w_clr;
  logic       w_stp;
  logic       w_sta;
  logic       w_lap;
  logic       w_mod;

  assign w_btn   = {mode_toggle, lap_button, clear_button,
                    stop_button, start_button};
  assign w_press = w_btn & ~r_btn_q;

  // Only the highest-priority press is acted on in a cycle.
  assign w_clr = w_press[2];
  assign w_stp = w_press[1] & ~w_press[2];
  assign w_sta = w_press[0] & ~|w_press[2:1];
  assign w_lap = w_press[3] & ~|w_press[2:0];
  assign w_mod = w_press[4] & ~|w_press[3:0];

  assign w_sel_ok = 32'(ch_sel) < NUM_CH;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_btn_q <= '0;
    else       r_btn_q <= w_btn;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]         r_state;
    logic               r_mode_down;
    logic               r_run;
    logic               r_dir;
    logic               r_clr;
    logic               r_lap;
    logic               r_alm;
    logic               r_load;
    logic [ALARM_W-1:0] r_cnt;
    logic               w_hit;
    logic               w_zero_run;
    logic               w_expire;
    logic               w_reload;

    assign w_hit      = w_sel_ok && (32'(ch_sel) == g);
    assign w_zero_run = (r_state == S_RUN) && !r_dir && at_zero[g];
    assign w_expire   = w_zero_run & ~LP_RELOAD;
    assign w_reload   = w_zero_run & LP_RELOAD;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_state     <= S_IDLE;
        r_mode_down <= 1'b0;
        r_run       <= 1'b0;
        r_dir       <= 1'b1;
        r_clr       <= 1'b0;
        r_lap       <= 1'b0;
        r_alm       <= 1'b0;
        r_load      <= 1'b0;
        r_cnt       <= '0;
      end else begin
        r_clr  <= 1'b0;
        r_load <= w_reload;
        if (w_expire) begin
          r_state <= S_EXPIRED;
          r_run   <= 1'b0;
          r_cnt   <= '0;
          r_alm   <= 1'b1;
        end else begin
          case (r_state)
            S_IDLE, S_PAUSED: begin
              if (w_hit && w_clr) begin
                r_clr   <= 1'b1;
                r_lap   <= 1'b0;
                r_state <= S_IDLE;
              end else if (w_hit && w_sta) begin
                if (!(r_mode_down && at_zero[g])) begin
                  r_state <= S_RUN;
                  r_run   <= 1'b1;
                  r_dir   <= ~r_mode_down;
                end
              end else if (w_hit && w_mod) begin
                r_mode_down <= ~r_mode_down;
              end
            end
            S_RUN: begin
              r_alm <= w_reload;
              if (w_hit && w_stp) begin
                r_state <= S_PAUSED;
                r_run   <= 1'b0;
              end else if (w_hit && w_lap) begin
                r_lap <= ~r_lap;
              end
            end
            default: begin
              // Alarm counter saturates; the channel waits for an acknowledge.
              if (r_cnt != LP_ALARM) begin
                r_cnt <= r_cnt + 1'b1;
                r_alm <= (r_cnt + 1'b1) < LP_ALARM;
              end
              if (w_hit && w_clr) begin
                r_clr   <= 1'b1;
                r_alm   <= 1'b0;
                r_lap   <= 1'b0;
                r_state <= S_IDLE;
              end else if (w_hit && (w_stp || w_sta)) begin
                r_alm   <= 1'b0;
                r_state <= S_PAUSED;
              end
            end
          endcase
        end
      end
    end

    assign running[g]     = r_run;
    assign direction[g]   = r_dir;
    assign clear_pulse[g] = r_clr;
    assign lap_hold[g]    = r_lap;
    assign alarm[g]       = r_alm;
    assign load_pulse[g]  = r_load;
  end

endmodule

// File: tb/tb_stopwatch_ctrl_mc.sv
// Scoreboard bench for stopwatch_ctrl_mc: 2 channels, 10-cycle alarm.
module tb_stopwatch_ctrl_mc;

  logic       clock;
  logic       reset;
  logic       start_button;
  logic       stop_button;
  logic       clear_button;
  logic       lap_button;
  logic       mode_toggle;
  logic [1:0] ch_sel;
  logic [1:0] at_zero;
  logic [1:0] running;
  logic [1:0] direction;
  logic [1:0] clear_pulse;
  logic [1:0] lap_hold;
  logic [1:0] alarm;
  logic [1:0] load_pulse;

  stopwatch_ctrl_mc #(
    .NUM_CH(2),
    .SEL_W(2),
    .ALARM_CYCLES(10),
    .ALARM_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_button(start_button),
    .stop_button(stop_button),
    .clear_button(clear_button),
    .lap_button(lap_button),
    .mode_toggle(mode_toggle),
    .ch_sel(ch_sel),
    .at_zero(at_zero),
    .running(running),
    .direction(direction),
    .clear_pulse(clear_pulse),
    .lap_hold(lap_hold),
    .alarm(alarm),
    .load_pulse(load_pulse)
  );

  typedef struct {
    string       nm;
    logic [11:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [1:0] e_run;
  logic [1:0] e_dir;
  logic [1:0] e_clr;
  logic [1:0] e_lap;
  logic [1:0] e_alm;
  logic [1:0] e_load;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every cycle the DUT presents registered outputs.
  initial begin
    exp_t        e;
    logic [11:0] got;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {load_pulse, alarm, lap_hold, clear_pulse, direction, running};
        n_tests++;
        if (got !== e.v) begin
          n_fail++;
          $display("FAIL %s got=%03h exp=%03h (load,alm,lap,clr,dir,run)",
                   e.nm, got, e.v);
        end
      end
    end
  end

  task automatic tick(input string nm);
    exp_t e;
    e.nm = nm;
    e.v  = {e_load, e_alm, e_lap, e_clr, e_dir, e_run};
    q.push_back(e);
    @(negedge clock);
    e_clr  = 2'b00;
    e_load = 2'b00;
  endtask

  initial begin
    reset        = 1'b1;
    start_button = 1'b0;
    stop_button  = 1'b0;
    clear_button = 1'b0;
    lap_button   = 1'b0;
    mode_toggle  = 1'b0;
    ch_sel       = 2'd0;
    at_zero      = 2'b00;
    e_run  = 2'b00;
    e_dir  = 2'b11;
    e_clr  = 2'b00;
    e_lap  = 2'b00;
    e_alm  = 2'b00;
    e_load = 2'b00;
    @(negedge clock);
    tick("reset");
    reset = 1'b0;
    tick("idle");

    // Held start acts once
    start_button = 1'b1;
    e_run = 2'b01;
    for (int i = 0; i < 5; i++) tick("start_hold");
    start_button = 1'b0;
    tick("start_rel");

    stop_button = 1'b1;
    e_run = 2'b00;
    tick("stop");
    stop_button = 1'b0;
    tick("stop_rel");
    clear_button = 1'b1;
    e_clr = 2'b01;
    tick("clear_paused");
    clear_button = 1'b0;
    tick("clear_one_cycle");

    start_button = 1'b1;
    e_run = 2'b01;
    tick("restart");
    start_button = 1'b0;
    tick("restart_rel");
    clear_button = 1'b1;
    tick("clear_in_run");
    clear_button = 1'b0;
    tick("clear_in_run_rel");

    lap_button = 1'b1;
    e_lap = 2'b01;
    tick("lap_on");
    lap_button = 1'b0;
    tick("lap_rel");
    lap_button = 1'b1;
    e_lap = 2'b00;
    tick("lap_off");
    lap_button = 1'b0;
    tick("lap_rel2");

    // Out-of-range channel ignores every button
    ch_sel = 2'd3;
    stop_button = 1'b1;
    lap_button  = 1'b1;
    tick("sel3_stop_lap");
    stop_button = 1'b0;
    lap_button  = 1'b0;
    clear_button = 1'b1;
    mode_toggle  = 1'b1;
    tick("sel3_clear_mode");
    clear_button = 1'b0;
    mode_toggle  = 1'b0;
    tick("sel3_rel");

    ch_sel = 2'd0;
    stop_button = 1'b1;
    e_run = 2'b00;
    tick("pause_ch0");
    stop_button = 1'b0;
    tick("pause_ch0_rel");
    start_button = 1'b1;
    clear_button = 1'b1;
    e_clr = 2'b01;
    tick("start_clear_prio");
    start_button = 1'b0;
    clear_button = 1'b0;
    tick("prio_rel");

    ch_sel = 2'd1;
    mode_toggle = 1'b1;
    tick("mode_ch1");
    mode_toggle = 1'b0;
    tick("mode_rel");
    at_zero = 2'b10;
    start_button = 1'b1;
    tick("start_zero_guard");
    start_button = 1'b0;
    at_zero = 2'b00;
    tick("guard_rel");
    start_button = 1'b1;
    e_run = 2'b10;
    e_dir = 2'b01;
    tick("start_down");
    start_button = 1'b0;
    tick("down_run");

`ifdef STOPWATCH_AUTO_RELOAD_EN
    at_zero = 2'b10;
    e_load = 2'b10;
    e_alm  = 2'b10;
    tick("reload");
    at_zero = 2'b00;
    e_alm = 2'b00;
    tick("reload_done");
    stop_button = 1'b1;
    e_run = 2'b00;
    tick("pause_ch1");
    stop_button = 1'b0;
    tick("pause_ch1_rel");
`else
    at_zero = 2'b10;
    e_run = 2'b00;
    e_alm = 2'b10;
    tick("expire");
    for (int i = 0; i < 9; i++) tick("alarm_on");
    e_alm = 2'b00;
    tick("alarm_off");
    tick("alarm_sat");
    clear_button = 1'b1;
    e_clr = 2'b10;
    tick("expired_clear");
    clear_button = 1'b0;
    tick("expired_clear_rel");

    at_zero = 2'b00;
    start_button = 1'b1;
    e_run = 2'b10;
    tick("start_down2");
    start_button = 1'b0;
    tick("down_run2");
    at_zero = 2'b10;
    stop_button = 1'b1;
    e_run = 2'b00;
    e_alm = 2'b10;
    tick("expire_beats_stop");
    stop_button = 1'b0;
    tick("expired_hold");
    start_button = 1'b1;
    e_alm = 2'b00;
    tick("ack_start");
    start_button = 1'b0;
    tick("ack_rel");
`endif

    // Up-counting channel ignores at_zero
    ch_sel = 2'd0;
    at_zero = 2'b11;
    start_button = 1'b1;
    e_run = 2'b01;
    tick("up_start_at_zero");
    start_button = 1'b0;
    for (int i = 0; i < 3; i++) tick("up_no_expire");

    @(posedge clock);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
